// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word RAM between instruction fetch and load/store,
// with data priority, fetch anti-starvation, RMW locking and 1-cycle read-data routing.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_lock,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-3:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  typedef enum logic [1:0] {P_NONE, P_INSTR, P_DATA, P_DERR} pend_t;

  logic [CW-1:0] r_wait_cnt;
  logic          r_lock_q;
  pend_t         r_pend;
  logic          w_aligned;
  logic          w_starve;
  logic          w_unused;

  assign w_aligned = d_addr[1:0] == 2'b00;
  assign w_starve  = i_req && (r_wait_cnt == CW'(MAX_WAIT));
  assign w_unused  = ^i_addr[1:0];

  // A held lock beats the starvation override so RMW pairs stay atomic
  assign d_gnt = reset_n && d_req && (r_lock_q || !w_starve);
  assign i_gnt = reset_n && i_req && !r_lock_q && (w_starve || !d_req);

  assign m_en    = i_gnt || (d_gnt && w_aligned);
  assign m_we    = d_gnt && d_we && w_aligned;
  assign m_addr  = d_gnt ? d_addr[AW-1:2] : i_addr[AW-1:2];
  assign m_wdata = d_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
      r_lock_q   <= 1'b0;
      r_pend     <= P_NONE;
    end else begin
      r_wait_cnt <= (!i_req || i_gnt) ? '0 :
                    (r_wait_cnt == CW'(MAX_WAIT)) ? r_wait_cnt : r_wait_cnt + CW'(1);
      r_lock_q   <= d_gnt && d_lock;
      r_pend     <= i_gnt ? P_INSTR : !d_gnt ? P_NONE : !w_aligned ? P_DERR : d_we ? P_NONE : P_DATA;
    end
  end

  assign i_rvalid = r_pend == P_INSTR;
  assign i_rdata  = m_rdata;
  assign d_rvalid = (r_pend == P_DATA) || (r_pend == P_DERR);
  assign d_err    = r_pend == P_DERR;
  assign d_rdata  = (r_pend == P_DATA) ? m_rdata : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed + random scoreboard bench; a reference model predicts grants
// and RAM contents, a monitor pops expected responses whenever rvalid appears.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, MW = 4;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic          i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0, m_rdata = '0;
  logic          i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, m_en, m_we;
  logic [DW-1:0] i_rdata, d_rdata, m_wdata;
  logic [AW-3:0] m_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_lock(d_lock), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Environment RAM driven only by the DUT's command
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (m_en && !m_we) m_rdata <= ram[m_addr[7:0]];
    if (m_en && m_we) ram[m_addr[7:0]] <= m_wdata;
  end

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {int due; logic err; logic [DW-1:0] data;} rsp_t;
  rsp_t qi[$], qd[$];

  // Reference model state: memory image, consecutive lost fetch cycles, lock flag
  logic [DW-1:0] ref_mem [0:255];
  int lost = 0;
  bit lock = 0;

  task automatic step(input bit ir, input logic [AW-1:0] ia, input bit dr, input bit dw,
                      input bit dl, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                      output bit ig, output bit dg);
    bit al;
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_lock = dl; d_addr = da; d_wdata = wd;
    al = da[1:0] == 2'b00;
    dg = dr && (lock || !(ir && lost >= MW));
    ig = ir && !lock && (lost >= MW || !dr);
    #1;
    chk("i_gnt", i_gnt, ig);
    chk("d_gnt", d_gnt, dg);
    chk("m_en", m_en, ig || (dg && al));
    chk("m_we", m_we, dg && dw && al);
    if (ig) chk("m_addr_i", m_addr, ia >> 2);
    if (dg && al) chk("m_addr_d", m_addr, da >> 2);
    if (dg && dw && al) chk("m_wdata", m_wdata, wd);
    if (ig) qi.push_back('{cyc + 1, 1'b0, ref_mem[ia[9:2]]});
    if (dg && !al) qd.push_back('{cyc + 1, 1'b1, '0});
    else if (dg && dw) ref_mem[da[9:2]] = wd;
    else if (dg) qd.push_back('{cyc + 1, 1'b0, ref_mem[da[9:2]]});
    lost = (ir && !ig) ? ((lost < MW) ? lost + 1 : MW) : 0;
    lock = dg && dl;
  endtask

  initial begin
    rsp_t r;
    forever begin
      @(posedge clk);
      #1;
      if (i_rvalid) begin
        if (qi.size() == 0 || qi[0].due != cyc) chk("i_rvalid_unexpected", i_rvalid, 1'b0);
        else begin r = qi.pop_front(); chk("i_rdata", i_rdata, r.data); end
      end else if (qi.size() > 0 && qi[0].due <= cyc) begin
        chk("i_rvalid_missing", i_rvalid, 1'b1);
        void'(qi.pop_front());
      end
      if (d_rvalid) begin
        if (qd.size() == 0 || qd[0].due != cyc) chk("d_rvalid_unexpected", d_rvalid, 1'b0);
        else begin
          r = qd.pop_front();
          chk("d_err", d_err, r.err);
          chk("d_rdata", d_rdata, r.data);
        end
      end else begin
        chk("d_err_idle", d_err, 1'b0);
        if (qd.size() > 0 && qd[0].due <= cyc) begin
          chk("d_rvalid_missing", d_rvalid, 1'b1);
          void'(qd.pop_front());
        end
      end
    end
  end

  initial begin
    bit ig, dg, pi, pd, ir, dr, dw, dl;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] wd;
    for (int k = 0; k < 256; k++) begin
      ram[k] = $urandom;
      ref_mem[k] = ram[k];
    end
    i_req = 1'b1; d_req = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_i_gnt", i_gnt, 1'b0);
    chk("rst_d_gnt", d_gnt, 1'b0);
    chk("rst_m_en", m_en, 1'b0);
    chk("rst_m_we", m_we, 1'b0);
    chk("rst_i_rvalid", i_rvalid, 1'b0);
    chk("rst_d_rvalid", d_rvalid, 1'b0);
    chk("rst_d_err", d_err, 1'b0);
    i_req = 1'b0; d_req = 1'b0;
    reset_n = 1'b1;

    step(1, 32'h40, 0, 0, 0, 0, 0, ig, dg);
    step(1, 32'h44, 1, 0, 0, 32'h80, 0, ig, dg);
    step(1, 32'h44, 0, 0, 0, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    for (int k = 0; k < 6; k++) step(1, 32'h48, 1, 0, 0, 32'h84 + 4 * k, 0, ig, dg);
    step(0, 0, 1, 1, 0, 32'h100, 32'hDEADBEEF, ig, dg);
    step(0, 0, 1, 0, 0, 32'h100, 0, ig, dg);
    step(0, 0, 1, 0, 0, 32'h102, 0, ig, dg);
    step(0, 0, 1, 1, 0, 32'h103, 32'h12345678, ig, dg);
    step(0, 0, 1, 0, 0, 32'h100, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    for (int k = 0; k < 6; k++) step(1, 32'h50, 1, k[0], k < 5, 32'h10 + 4 * k, $urandom, ig, dg);
    step(1, 32'h50, 1, 0, 0, 32'h30, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    step(1, 32'h200, 0, 0, 0, 0, 0, ig, dg);
    #1 reset_n = 1'b0;
    qi.delete(); qd.delete();
    lost = 0; lock = 0;
    #1;
    chk("midrst_i_gnt", i_gnt, 1'b0);
    chk("midrst_m_en", m_en, 1'b0);
    @(posedge clk);
    #2;
    chk("midrst_i_rvalid", i_rvalid, 1'b0);
    @(negedge clk);
    i_req = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    chk("postrst_i_rvalid", i_rvalid, 1'b0);

    pi = 0; pd = 0; ir = 0; dr = 0; dw = 0; dl = 0; ia = '0; da = '0; wd = '0;
    for (int n = 0; n < 600; n++) begin
      if (!pi) begin
        ir = $urandom_range(0, 1) == 1;
        ia = 32'($urandom_range(0, 1023));
        pi = ir;
      end
      if (!pd) begin
        dr = $urandom_range(0, 2) != 0;
        dw = $urandom_range(0, 1) == 1;
        da = 32'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 7) == 0) da[1:0] = 2'($urandom_range(1, 3));
        wd = $urandom;
        pd = dr;
      end
      dl = $urandom_range(0, 3) == 0;
      step(ir, ia, dr, dw, dl, da, wd, ig, dg);
      if (ig) begin pi = 0; ir = 0; end
      if (dg) begin pd = 0; dr = 0; end
    end
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    step(0, 0, 0, 0, 0, 0, 0, ig, dg);
    chk("qi_drained", 64'(qi.size()), 0);
    chk("qd_drained", 64'(qd.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
